keypad_number_entry: RTL and testbench

- Input-side counterpart of the seven-segment display driver. Scans a 4x4 matrix keypad (Pmod KYPD layout), debounces it, and assembles up to four decimal digits into a binary number 0..9999.
- The live entry value feeds the display driver's number input. A submitted value goes to game logic with a one-cycle valid pulse.
- Sits between the board keypad pins and the lab4 game controller.

---
 rtl/keypad_number_entry.sv | 249 ++++++++++++++++++++++++
 tb/tb_keypad_number_entry.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_number_entry.sv
// 4x4 matrix keypad scanner with frame-level debounce and a decimal entry FSM.
// Builds a 0..9999 number from keypresses and hands it to game logic on enter.
module keypad_number_entry #(
  parameter int unsigned SCAN_CYCLES     = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clock_100Mhz,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] number,
  output logic [2:0]  entry_digits,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [15:0] value,
  output logic        value_valid
);

  localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned STB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_FULL = STB_W'(DEBOUNCE_FRAMES);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ENTRY     = 2'd1;
  localparam logic [1:0] ST_SUBMITTED = 2'd2;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  // Keypad label at row r, column c.
  function automatic logic [3:0] key_label(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] lbl;
    case ({r, c})
      4'h0: lbl = 4'h1;  4'h1: lbl = 4'h2;  4'h2: lbl = 4'h3;  4'h3: lbl = 4'hA;
      4'h4: lbl = 4'h4;  4'h5: lbl = 4'h5;  4'h6: lbl = 4'h6;  4'h7: lbl = 4'hB;
      4'h8: lbl = 4'h7;  4'h9: lbl = 4'h8;  4'hA: lbl = 4'h9;  4'hB: lbl = 4'hC;
      4'hC: lbl = 4'h0;  4'hD: lbl = 4'hF;  4'hE: lbl = 4'hE;  default: lbl = 4'hD;
    endcase
    return lbl;
  endfunction

  // Row synchronizer; idles at "no key" so a reset never looks like a press.
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Column scan timing.
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       col_idx_nx;
  logic             scan_tick;
  logic             frame_done;

  assign scan_tick  = (scan_cnt == CNT_LAST);
  assign col_idx_nx = col_idx + 2'd1;
  assign frame_done = scan_tick && (col_idx == 2'd3);

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      col_idx  <= 2'd0;
      col      <= 4'b1110;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      col_idx  <= col_idx_nx;
      col      <= ~(4'b0001 << col_idx_nx);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Per-column sample: any / multiple rows low, and the label of the low row.
  logic [3:0] row_low;
  logic       col_any;
  logic       col_multi;
  logic [1:0] row_idx;
  logic [3:0] col_code;

  assign row_low   = ~row_sync;
  assign col_any   = |row_low;
  assign col_multi = |(row_low & (row_low - 4'd1));
  assign col_code  = key_label(row_idx, col_idx);

  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_low[i]) row_idx = 2'(i);
    end
  end

  // Frame accumulator: two or more keys anywhere in the frame collapse to NONE.
  logic       acc_any;
  logic       acc_multi;
  logic [3:0] acc_code;
  logic       tot_any;
  logic       tot_multi;
  logic [3:0] tot_code;
  logic       res_key;
  logic [4:0] frame_res;

  assign tot_any   = acc_any | col_any;
  assign tot_multi = acc_multi | col_multi | (acc_any & col_any);
  assign tot_code  = col_any ? col_code : acc_code;
  assign res_key   = tot_any & ~tot_multi;
  assign frame_res = {res_key, res_key ? tot_code : 4'h0};

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      acc_any   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'h0;
    end else if (frame_done) begin
      acc_any   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'h0;
    end else if (scan_tick) begin
      acc_any   <= tot_any;
      acc_multi <= tot_multi;
      acc_code  <= tot_code;
    end
  end

  // Debounce over whole frames; held blocks repeats until NONE is stable.
  logic [4:0]       prev_res;
  logic [STB_W-1:0] stable_cnt;
  logic [STB_W-1:0] stable_nx;
  logic             stable_full;
  logic             held;

  always_comb begin
    stable_nx = stable_cnt;
    if (frame_res == prev_res) begin
      if (stable_cnt != STB_FULL) stable_nx = stable_cnt + STB_W'(1);
    end else begin
      stable_nx = STB_W'(1);
    end
  end

  assign stable_full = (stable_nx == STB_FULL);

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      prev_res   <= 5'd0;
      stable_cnt <= '0;
      held       <= 1'b0;
      key_strobe <= 1'b0;
      key_code   <= 4'h0;
    end else begin
      key_strobe <= 1'b0;
      if (frame_done) begin
        prev_res   <= frame_res;
        stable_cnt <= stable_nx;
        if (stable_full) begin
          if (!frame_res[4]) begin
            held <= 1'b0;
          end else if (!held) begin
            key_strobe <= 1'b1;
            key_code   <= frame_res[3:0];
            held       <= 1'b1;
          end
        end
      end
    end
  end

  // Entry FSM: acts on the cycle after each accepted keypress.
  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [15:0] number_nx;
  logic [2:0]  digits_nx;
  logic [15:0] value_nx;
  logic        valid_nx;

  always_comb begin
    state_nx  = state;
    number_nx = number;
    digits_nx = entry_digits;
    value_nx  = value;
    valid_nx  = 1'b0;
    if (key_strobe) begin
      if (key_code <= 4'd9) begin
        if (state != ST_ENTRY) begin
          number_nx = 16'(key_code);
          digits_nx = 3'd1;
          state_nx  = ST_ENTRY;
        end else if (entry_digits < 3'd4) begin
          number_nx = 16'(17'(number) * 17'd10 + 17'(key_code));
          digits_nx = entry_digits + 3'd1;
        end
      end else begin
        case (key_code)
          KEY_ENTER: begin
            if (state == ST_ENTRY) begin
              value_nx = number;
              valid_nx = 1'b1;
              state_nx = ST_SUBMITTED;
            end
          end
          KEY_BACK: begin
            if (state == ST_ENTRY) begin
              if (entry_digits == 3'd1) begin
                number_nx = 16'd0;
                digits_nx = 3'd0;
                state_nx  = ST_IDLE;
              end else begin
                number_nx = number / 16'd10;
                digits_nx = entry_digits - 3'd1;
              end
            end
          end
          KEY_CLEAR: begin
            number_nx = 16'd0;
            digits_nx = 3'd0;
            state_nx  = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      number       <= 16'd0;
      entry_digits <= 3'd0;
      value        <= 16'd0;
      value_valid  <= 1'b0;
    end else begin
      state        <= state_nx;
      number       <= number_nx;
      entry_digits <= digits_nx;
      value        <= value_nx;
      value_valid  <= valid_nx;
    end
  end

endmodule

// File: tb/tb_keypad_number_entry.sv
// Bench for keypad_number_entry: keypad matrix model, digit-list entry model, randomized keys.
module tb_keypad_number_entry;

  localparam int unsigned SCAN = 4;
  localparam int unsigned DEB  = 2;

  logic        clk;
  logic        reset_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] number;
  logic [2:0]  entry_digits;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] value;
  logic        value_valid;
  logic [15:0] pressed;

  int checks;
  int passed;
  int strobe_cnt;
  int vv_cycles;
  logic [3:0]  last_code;
  logic [15:0] vv_last;

  // Entry model: list of typed digits plus a submitted flag.
  int md[$];
  bit m_sub;
  int m_value;
  int m_vv_total;
  int m_strobes;

  keypad_number_entry #(.SCAN_CYCLES(SCAN), .DEBOUNCE_FRAMES(DEB)) dut (
    .clock_100Mhz(clk), .reset_n(reset_n), .row(row), .col(col),
    .number(number), .entry_digits(entry_digits), .key_strobe(key_strobe),
    .key_code(key_code), .value(value), .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  // Pressed key r,c pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_strobe) begin
      strobe_cnt++;
      last_code = key_code;
    end
    if (value_valid) begin
      vv_cycles++;
      vv_last = value;
    end
  end

  function automatic logic [15:0] key_mask(input int code);
    int idx;
    case (code)
      1: idx = 0;   2: idx = 1;   3: idx = 2;   10: idx = 3;
      4: idx = 4;   5: idx = 5;   6: idx = 6;   11: idx = 7;
      7: idx = 8;   8: idx = 9;   9: idx = 10;  12: idx = 11;
      0: idx = 12;  15: idx = 13; 14: idx = 14; default: idx = 15;
    endcase
    return 16'd1 << idx;
  endfunction

  function automatic int model_number();
    int n = 0;
    foreach (md[i]) n = n * 10 + md[i];
    return n;
  endfunction

  task automatic model_key(input int code);
    bit in_entry;
    in_entry = (md.size() != 0) && !m_sub;
    m_strobes++;
    if (code <= 9) begin
      if (!in_entry) begin
        md.delete();
        md.push_back(code);
        m_sub = 0;
      end else if (md.size() < 4) begin
        md.push_back(code);
      end
    end else if (code == 10) begin
      if (in_entry) begin
        m_value = model_number();
        m_sub = 1;
        m_vv_total++;
      end
    end else if (code == 11) begin
      if (in_entry) void'(md.pop_back());
    end else if (code == 12) begin
      md.delete();
      m_sub = 0;
    end
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    while (col == 4'b1110 && n < 40) begin @(posedge clk); #1; n++; end
    while (col != 4'b1110 && n < 80) begin @(posedge clk); #1; n++; end
    if (col != 4'b1110) begin
      checks++;
      $display("FAIL frame_start_timeout: col=%b after %0d cycles, required 1110", col, n);
    end
  endtask

  task automatic hold(input logic [15:0] m, input int frames);
    repeat (frames) begin
      wait_frame_start();
      pressed = m;
    end
  endtask

  task automatic press_key(input int code);
    hold(key_mask(code), 3);
    hold(16'd0, 3);
    model_key(code);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    reset_n = 1'b0;
    pressed = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (col !== 4'b1110) $display("FAIL reset_col: got %b required 1110", col); else passed++;
    checks++; if (number !== 16'd0 || entry_digits !== 3'd0) $display("FAIL reset_number: got %0d/%0d required 0/0", number, entry_digits); else passed++;
    checks++; if (key_code !== 4'h0 || key_strobe !== 1'b0) $display("FAIL reset_key: got code %h strobe %b required 0/0", key_code, key_strobe); else passed++;
    checks++; if (value !== 16'd0 || value_valid !== 1'b0) $display("FAIL reset_value: got %0d valid %b required 0/0", value, value_valid); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      checks++; if (col !== exp_col) $display("FAIL scan_col[%0d]: got %b required %b", k, col, exp_col); else passed++;
      checks++;
      if (key_strobe !== 1'b0 || value_valid !== 1'b0 || number !== 16'd0 || entry_digits !== 3'd0)
        $display("FAIL scan_quiet[%0d]: strobe %b valid %b number %0d digits %0d required all 0", k, key_strobe, value_valid, number, entry_digits);
      else passed++;
    end
  endtask

  task automatic test_single_bounce();
    int s0;
    s0 = strobe_cnt;
    hold(key_mask(5), 1);
    hold(16'd0, 1);
    hold(key_mask(5), 10);
    model_key(5);
    checks++; if (strobe_cnt - s0 != 1) $display("FAIL bounce_press_strobes: got %0d required 1", strobe_cnt - s0); else passed++;
    checks++; if (key_code !== 4'h5) $display("FAIL bounce_key_code: got %h required 5", key_code); else passed++;
    checks++; if (number !== 16'd5 || entry_digits !== 3'd1) $display("FAIL bounce_number: got %0d/%0d required 5/1", number, entry_digits); else passed++;
    hold(16'd0, 1);
    hold(key_mask(5), 1);
    hold(16'd0, 3);
    checks++; if (strobe_cnt - s0 != 1) $display("FAIL bounce_release_strobes: got %0d required 1", strobe_cnt - s0); else passed++;
  endtask

  task automatic test_entry_submit();
    int v0;
    int seq[5] = '{1, 2, 3, 4, 9};
    press_key(12);
    foreach (seq[i]) press_key(seq[i]);
    checks++; if (number !== 16'd1234 || number !== 16'(model_number())) $display("FAIL entry_number: got %0d required 1234", number); else passed++;
    checks++; if (entry_digits !== 3'd4) $display("FAIL entry_digits: got %0d required 4", entry_digits); else passed++;
    v0 = vv_cycles;
    press_key(10);
    checks++; if (vv_cycles - v0 != 1) $display("FAIL submit_pulse_cycles: got %0d required 1", vv_cycles - v0); else passed++;
    checks++; if (value !== 16'd1234 || vv_last !== 16'd1234) $display("FAIL submit_value: got %0d (at pulse %0d) required 1234", value, vv_last); else passed++;
    checks++; if (number !== 16'd1234) $display("FAIL submit_keeps_number: got %0d required 1234", number); else passed++;
  endtask

  task automatic test_backspace_clear();
    int v0;
    press_key(4);
    press_key(0);
    press_key(7);
    press_key(11);
    checks++; if (number !== 16'(model_number()) || entry_digits !== 3'(md.size())) $display("FAIL backspace: got %0d/%0d required %0d/%0d", number, entry_digits, model_number(), md.size()); else passed++;
    checks++; if (number !== 16'd40) $display("FAIL backspace_value40: got %0d required 40", number); else passed++;
    press_key(12);
    checks++; if (number !== 16'd0 || entry_digits !== 3'd0) $display("FAIL clear: got %0d/%0d required 0/0", number, entry_digits); else passed++;
    checks++; if (value !== 16'(m_value)) $display("FAIL clear_keeps_value: got %0d required %0d", value, m_value); else passed++;
    v0 = vv_cycles;
    press_key(10);
    checks++; if (vv_cycles != v0) $display("FAIL enter_in_idle: got %0d pulse cycles required 0", vv_cycles - v0); else passed++;
  endtask

  task automatic test_multikey();
    int s0;
    s0 = strobe_cnt;
    hold(key_mask(1) | key_mask(6), 4);
    hold(16'd0, 3);
    checks++; if (strobe_cnt != s0) $display("FAIL multikey_strobes: got %0d required 0", strobe_cnt - s0); else passed++;
    hold(key_mask(3), 3);
    hold(key_mask(9), 4);
    hold(16'd0, 3);
    model_key(3);
    checks++; if (strobe_cnt - s0 != 1) $display("FAIL slide_strobes: got %0d required 1", strobe_cnt - s0); else passed++;
    checks++; if (last_code !== 4'h3 || key_code !== 4'h3) $display("FAIL slide_code: got %h required 3", key_code); else passed++;
    checks++; if (number !== 16'(model_number()) || entry_digits !== 3'(md.size())) $display("FAIL slide_number: got %0d/%0d required %0d/%0d", number, entry_digits, model_number(), md.size()); else passed++;
  endtask

  task automatic test_random_keys();
    int s0;
    int code;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 6) code = int'($urandom_range(0, 9));
      else code = int'($urandom_range(10, 15));
      s0 = strobe_cnt;
      press_key(code);
      checks++; if (strobe_cnt - s0 != 1 || last_code !== 4'(code)) $display("FAIL rand_strobe[%0d]: got %0d strobes code %h required 1 code %h", n, strobe_cnt - s0, last_code, code); else passed++;
      checks++; if (number !== 16'(model_number()) || entry_digits !== 3'(md.size())) $display("FAIL rand_number[%0d]: got %0d/%0d required %0d/%0d", n, number, entry_digits, model_number(), md.size()); else passed++;
      checks++; if (value !== 16'(m_value) || vv_cycles != m_vv_total) $display("FAIL rand_value[%0d]: got %0d pulses %0d required %0d pulses %0d", n, value, vv_cycles, m_value, m_vv_total); else passed++;
    end
  endtask

  task automatic test_reset_mid_entry();
    int s0;
    press_key(12);
    press_key(5);
    press_key(6);
    checks++; if (number !== 16'd56) $display("FAIL pre_reset_number: got %0d required 56", number); else passed++;
    wait_frame_start();
    pressed = key_mask(7);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    md.delete();
    m_sub = 0;
    m_value = 0;
    checks++; if (col !== 4'b1110 || number !== 16'd0 || entry_digits !== 3'd0) $display("FAIL async_reset: got col %b number %0d digits %0d required 1110/0/0", col, number, entry_digits); else passed++;
    checks++; if (value !== 16'd0 || key_code !== 4'h0) $display("FAIL async_reset_value: got %0d code %h required 0/0", value, key_code); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    s0 = strobe_cnt;
    repeat (5 * 4 * SCAN) @(posedge clk);
    #1;
    model_key(7);
    checks++; if (strobe_cnt - s0 != 1 || last_code !== 4'h7) $display("FAIL held_through_reset: got %0d strobes code %h required 1 code 7", strobe_cnt - s0, last_code); else passed++;
    checks++; if (number !== 16'd7 || entry_digits !== 3'd1) $display("FAIL held_through_reset_number: got %0d/%0d required 7/1", number, entry_digits); else passed++;
    hold(16'd0, 3);
    checks++; if (strobe_cnt != m_strobes) $display("FAIL total_strobes: got %0d required %0d", strobe_cnt, m_strobes); else passed++;
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    pressed = 16'd0;
    checks = 0;
    passed = 0;
    strobe_cnt = 0;
    vv_cycles = 0;
    last_code = 4'h0;
    vv_last = 16'd0;
    m_sub = 0;
    m_value = 0;
    m_vv_total = 0;
    m_strobes = 0;
    test_reset();
    test_single_bounce();
    test_entry_submit();
    test_backspace_clear();
    test_multikey();
    test_random_keys();
    test_reset_mid_entry();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
